// File: rtl/disparity_scan_ctrl_if.sv
// Cost-engine request/response bus between the disparity sweep controller
// (master) and the shared matching-cost engine (slave).
interface disparity_scan_ctrl_if #(
    parameter int DW = 18,
    parameter int PW = 6
);
    logic          cost_req;
    logic [PW-1:0] cost_pos;
    logic          cost_vld;
    logic [DW-1:0] cost_data;

    modport master (
        output cost_req,
        output cost_pos,
        input  cost_vld,
        input  cost_data
    );

    modport slave (
        input  cost_req,
        input  cost_pos,
        output cost_vld,
        output cost_data
    );
endinterface

// File: rtl/disparity_scan_ctrl.sv
// Disparity sweep sequencer: walks cost_pos from pos_first to pos_last over
// the cost engine, keeps the earliest minimum-cost position, and publishes it
// with a one-cycle done pulse. All outputs come straight from flops.
module disparity_scan_ctrl #(
    parameter int DW = 18,
    parameter int PW = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PW-1:0]        pos_first,
    input  logic [PW-1:0]        pos_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [DW-1:0]        best_cost,
    output logic [PW-1:0]        best_pos,
    disparity_scan_ctrl_if.master cost
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          req_q, req_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          first_q, first_d;
    logic [DW-1:0] best_cost_q, best_cost_d;
    logic [PW-1:0] best_pos_q, best_pos_d;
    logic [PW-1:0] last_q, last_d;
    logic [DW-1:0] run_cost_q, run_cost_d;
    logic [PW-1:0] run_pos_q, run_pos_d;

    // Minimum-select: first sample always loads, later ones only if strictly
    // smaller, so ties keep the earliest position.
    function automatic logic take_sample(input logic          first,
                                         input logic [DW-1:0] data,
                                         input logic [DW-1:0] run);
        return first || (data < run);
    endfunction

    // Next-state and next-output decode for the IDLE/SCAN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        req_d       = req_q;
        pos_d       = pos_q;
        first_d     = first_q;
        best_cost_d = best_cost_q;
        best_pos_d  = best_pos_q;
        last_d      = last_q;
        run_cost_d  = run_cost_q;
        run_pos_d   = run_pos_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    last_d = pos_last;
                    if (pos_first > pos_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SCAN;
                        req_d   = 1'b1;
                        pos_d   = pos_first;
                        first_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    req_d   = 1'b0;
                end else if (cost.cost_vld) begin
                    if (take_sample(first_q, cost.cost_data, run_cost_q)) begin
                        run_cost_d = cost.cost_data;
                        run_pos_d  = pos_q;
                    end
                    first_d = 1'b0;
                    if (pos_q == last_q) begin
                        // Publish including the sample consumed on this edge.
                        state_d     = DONE;
                        req_d       = 1'b0;
                        done_d      = 1'b1;
                        best_cost_d = run_cost_d;
                        best_pos_d  = run_pos_d;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    // Control state and published outputs, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_q       <= 1'b0;
            pos_q       <= '0;
            first_q     <= 1'b0;
            best_cost_q <= '1;
            best_pos_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            req_q       <= req_d;
            pos_q       <= pos_d;
            first_q     <= first_d;
            best_cost_q <= best_cost_d;
            best_pos_q  <= best_pos_d;
        end
    end

    // Sweep-local data registers; only read while scanning, so no reset.
    always_ff @(posedge clk) begin
        last_q     <= last_d;
        run_cost_q <= run_cost_d;
        run_pos_q  <= run_pos_d;
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign best_cost     = best_cost_q;
    assign best_pos      = best_pos_q;
    assign cost.cost_req = req_q;
    assign cost.cost_pos = pos_q;

endmodule

// File: tb/tb_disparity_scan_ctrl.sv
// Self-checking bench for disparity_scan_ctrl: sweep-level reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized sweeps.
module tb_disparity_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [5:0]  pos_first;
    logic [5:0]  pos_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [17:0] best_cost;
    logic [5:0]  best_pos;

    int total = 0;
    int bad   = 0;

    logic [17:0] cost_tab [64];
    bit          gap_mode = 0;
    int          gap_cnt  = 0;

    disparity_scan_ctrl_if #(.DW(18), .PW(6)) cif ();

    disparity_scan_ctrl #(.DW(18), .PW(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pos_first (pos_first),
        .pos_last  (pos_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .best_cost (best_cost),
        .best_pos  (best_pos),
        .cost      (cif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the sweep as a whole (active range, collected
    // samples) and derives the result by scanning the sample list at the end.
    bit          m_busy = 0, m_done = 0, m_err = 0, m_req = 0, m_indone = 0;
    logic [5:0]  m_pos = 0, m_first = 0, m_last = 0;
    logic [17:0] m_best_cost = '1;
    logic [5:0]  m_best_pos = 0;
    logic [17:0] samp [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_req = 0; m_indone = 0;
            m_pos = 0; m_best_cost = '1; m_best_pos = 0;
            samp.delete();
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_indone) begin
                m_indone = 0;
                m_busy   = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy  = 1;
                    m_first = pos_first;
                    m_last  = pos_last;
                    if (pos_first > pos_last) begin
                        m_done = 1; m_err = 1; m_indone = 1;
                    end else begin
                        m_req = 1; m_pos = pos_first;
                        samp.delete();
                    end
                end
            end else if (abort) begin
                m_busy = 0; m_req = 0;
            end else if (cif.cost_vld) begin
                samp.push_back(cif.cost_data);
                if (m_pos == m_last) begin
                    int mi;
                    logic [17:0] mc;
                    mi = 0; mc = samp[0];
                    foreach (samp[i]) if (samp[i] < mc) begin mc = samp[i]; mi = i; end
                    m_best_cost = mc;
                    m_best_pos  = 6'(int'(m_first) + mi);
                    m_req = 0; m_done = 1; m_indone = 1;
                end else begin
                    m_pos = m_pos + 6'd1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("cost_req", 32'(cif.cost_req), 32'(m_req));
        chk("best_cost", 32'(best_cost), 32'(m_best_cost));
        chk("best_pos", 32'(best_pos), 32'(m_best_pos));
        if (m_req) chk("cost_pos", 32'(cif.cost_pos), 32'(m_pos));
    end

    task automatic drive_resp();
        if (gap_mode) begin
            if (gap_cnt == 0) begin
                cif.cost_vld = 1'b1;
                gap_cnt = $urandom_range(0, 3);
            end else begin
                cif.cost_vld = 1'b0;
                gap_cnt = gap_cnt - 1;
            end
        end else begin
            cif.cost_vld = 1'b1;
        end
        cif.cost_data = cost_tab[cif.cost_pos];
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_req"}, 32'(cif.cost_req), 32'd0);
        chk({tag, "_pos"}, 32'(cif.cost_pos), 32'd0);
        chk({tag, "_bcost"}, 32'(best_cost), 32'h3FFFF);
        chk({tag, "_bpos"}, 32'(best_pos), 32'd0);
    endtask

    task automatic idle(input int n, output int ndone);
        ndone = 0;
        repeat (n) begin
            @(negedge clk);
            start = 0; abort = 0;
            drive_resp();
            if (done) ndone++;
        end
    endtask

    // One sweep: start, optional start-while-busy poke, optional abort or
    // asynchronous reset at a given position; reports the done cycle.
    task automatic sweep(input int first, input int last, input int abort_at,
                         input int rst_at, input bit poke,
                         output bit saw_done, output int dcyc, output bit derr);
        bit stop;
        saw_done = 0; dcyc = 0; derr = 0; stop = 0;
        @(negedge clk);
        pos_first = 6'(first); pos_last = 6'(last);
        start = 1; abort = 0;
        drive_resp();
        for (int k = 1; k <= 400 && !stop; k++) begin
            @(negedge clk);
            start = 0; abort = 0;
            pos_first = 6'($urandom); pos_last = 6'($urandom);
            drive_resp();
            if (done) begin
                saw_done = 1; dcyc = k; derr = err; stop = 1;
            end else if (poke && k == 3) begin
                start = 1;
            end else if (abort_at >= 0 && cif.cost_req && int'(cif.cost_pos) == abort_at) begin
                abort = 1; cif.cost_vld = 1'b1; stop = 1;
            end else if (rst_at >= 0 && cif.cost_req && int'(cif.cost_pos) == rst_at) begin
                #2 rst_n = 0;
                #1 chk_reset_vals("midrst");
                @(negedge clk);
                rst_n = 1; stop = 1;
            end
        end
        if (!stop) chk("sweep_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit          sd, de;
        int          dc, nd;
        logic [17:0] ref_c;
        int          ref_p;

        rst_n = 0; start = 0; abort = 0; pos_first = 0; pos_last = 0;
        cif.cost_vld = 0; cif.cost_data = 0;
        foreach (cost_tab[i]) cost_tab[i] = 18'($urandom);
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1;

        // Range 0..3, tie keeps earliest.
        cost_tab[0] = 18'd40; cost_tab[1] = 18'd12; cost_tab[2] = 18'd12; cost_tab[3] = 18'd30;
        sweep(0, 3, -1, -1, 0, sd, dc, de);
        chk("t1_done_cycle", 32'(dc), 32'd5);
        chk("t1_err", 32'(de), 32'd0);
        chk("t1_best_cost", 32'(best_cost), 32'd12);
        chk("t1_best_pos", 32'(best_pos), 32'd1);

        // Single-position range at the cost ceiling.
        cost_tab[5] = 18'h3FFFF;
        sweep(5, 5, -1, -1, 0, sd, dc, de);
        chk("t2_done_cycle", 32'(dc), 32'd2);
        chk("t2_best_cost", 32'(best_cost), 32'h3FFFF);
        chk("t2_best_pos", 32'(best_pos), 32'd5);

        // Illegal range.
        sweep(9, 4, -1, -1, 0, sd, dc, de);
        chk("t3_done_cycle", 32'(dc), 32'd1);
        chk("t3_err", 32'(de), 32'd1);
        chk("t3_best_cost", 32'(best_cost), 32'h3FFFF);
        chk("t3_best_pos", 32'(best_pos), 32'd5);

        // Gapped responses.
        gap_mode = 1; gap_cnt = 0;
        cost_tab[10] = 18'd7; cost_tab[11] = 18'd3; cost_tab[12] = 18'd9; cost_tab[13] = 18'd2;
        sweep(10, 13, -1, -1, 0, sd, dc, de);
        chk("t4_done", 32'(sd), 32'd1);
        chk("t4_best_cost", 32'(best_cost), 32'd2);
        chk("t4_best_pos", 32'(best_pos), 32'd13);
        gap_mode = 0;

        // Abort with simultaneous cost_vld at pos 20.
        foreach (cost_tab[i]) cost_tab[i] = 18'($urandom);
        sweep(0, 63, 20, -1, 0, sd, dc, de);
        idle(4, nd);
        chk("t5_no_done", 32'(sd) + 32'(nd), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_best_cost", 32'(best_cost), 32'd2);
        chk("t5_best_pos", 32'(best_pos), 32'd13);

        // Full sweep with a start pulse while busy.
        ref_c = cost_tab[0]; ref_p = 0;
        for (int i = 1; i < 64; i++) if (cost_tab[i] < ref_c) begin ref_c = cost_tab[i]; ref_p = i; end
        sweep(0, 63, -1, -1, 1, sd, dc, de);
        chk("t6_done_cycle", 32'(dc), 32'd65);
        chk("t6_best_cost", 32'(best_cost), 32'(ref_c));
        chk("t6_best_pos", 32'(best_pos), 32'(ref_p));

        // Asynchronous reset at pos 30.
        sweep(0, 63, -1, 30, 0, sd, dc, de);
        idle(3, nd);
        chk("t7_no_done", 32'(sd) + 32'(nd), 32'd0);

        // Randomized sweeps.
        for (int it = 0; it < 16; it++) begin
            int f, l, ab;
            foreach (cost_tab[i]) cost_tab[i] = ($urandom_range(0, 3) == 0) ? 18'($urandom_range(0, 7)) : 18'($urandom);
            f  = $urandom_range(0, 63);
            l  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 63) : $urandom_range(f, 63);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 63) : -1;
            gap_mode = bit'($urandom_range(0, 1));
            sweep(f, l, ab, -1, bit'($urandom_range(0, 1)), sd, dc, de);
            idle($urandom_range(0, 3), nd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
